// File: rtl/mem_be_resp.sv
// +-----------------------------------------------------------------------------+
// | mem_be_resp: single-port RAM with byte enables, range errors, backpressured |
// | response slot and a post-reset clearing sweep.   Rev 1.0                    |
// +-----------------------------------------------------------------------------+
`default_nettype none

module mem_be_resp #(
  parameter int WIDTH      = 32,
  parameter int DEPTH      = 24,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  localparam int NBYTES    = WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_wr,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [WIDTH-1:0]      req_wdata,
  input  logic [NBYTES-1:0]     req_be,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_wr,
  output logic [WIDTH-1:0]      rsp_rdata,
  output logic                  rsp_err,
  output logic                  busy
);

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  logic [WIDTH-1:0] mem [DEPTH];

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   clr_ptr_q, clr_ptr_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic                    rsp_wr_q, rsp_wr_d;
  logic                    rsp_err_q, rsp_err_d;
  logic                    rsp_rd_q, rsp_rd_d;
  logic [WIDTH-1:0]        ram_rdata_q;

  logic                    ram_we;
  logic                    ram_re;
  logic [ADDR_WIDTH-1:0]   ram_addr;
  logic [WIDTH-1:0]        ram_wdata;
  logic [NBYTES-1:0]       ram_be;
  logic                    accept;
  logic                    in_range;

  assign in_range  = (req_addr <= LAST_ADDR);
  assign req_ready = (state_q == ST_RUN) && (!rsp_valid_q || rsp_ready);
  assign accept    = req_valid && req_ready;

  always_comb begin
    state_d     = state_q;
    clr_ptr_d   = clr_ptr_q;
    rsp_valid_d = rsp_valid_q;
    rsp_wr_d    = rsp_wr_q;
    rsp_err_d   = rsp_err_q;
    rsp_rd_d    = rsp_rd_q;
    ram_we      = 1'b0;
    ram_re      = 1'b0;
    ram_addr    = req_addr;
    ram_wdata   = req_wdata;
    ram_be      = req_be;

    if (rsp_valid_q && rsp_ready) begin
      rsp_valid_d = 1'b0;
      rsp_wr_d    = 1'b0;
      rsp_err_d   = 1'b0;
      rsp_rd_d    = 1'b0;
    end

    case (state_q)
      ST_CLEAR: begin
        ram_we    = 1'b1;
        ram_addr  = clr_ptr_q;
        ram_wdata = '0;
        ram_be    = '1;
        clr_ptr_d = clr_ptr_q + ADDR_WIDTH'(1);
        if (clr_ptr_q == LAST_ADDR) begin
          state_d = ST_RUN;
        end
      end
      default: begin
        // A new accept overwrites the slot, including one being handed off this edge.
        if (accept) begin
          rsp_valid_d = 1'b1;
          rsp_wr_d    = req_wr;
          rsp_err_d   = !in_range;
          rsp_rd_d    = !req_wr && in_range;
          ram_we      = req_wr && in_range;
          ram_re      = !req_wr && in_range;
        end
      end
    endcase

    // The array is left alone during the reset cycle itself.
    if (rst) begin
      ram_we = 1'b0;
      ram_re = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_CLEAR;
      clr_ptr_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_wr_q    <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rd_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      clr_ptr_q   <= clr_ptr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_wr_q    <= rsp_wr_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rd_q    <= rsp_rd_d;
    end
  end

  // Unreset storage with a registered read port keeps this inferable as block RAM.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      for (int k = 0; k < NBYTES; k++) begin
        if (ram_be[k]) begin
          mem[ram_addr][8*k +: 8] <= ram_wdata[8*k +: 8];
        end
      end
    end
    if (ram_re) begin
      ram_rdata_q <= mem[ram_addr];
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_wr    = rsp_wr_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rd_q ? ram_rdata_q : '0;
  assign busy      = (state_q == ST_CLEAR);

endmodule

`default_nettype wire

// File: tb/tb_mem_be_resp.sv
// +-----------------------------------------------------------------------------+
// | tb_mem_be_resp: scoreboard bench for mem_be_resp (32x24 default config).    |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
`default_nettype none

module tb_mem_be_resp;

  localparam int WIDTH = 32;
  localparam int DEPTH = 24;
  localparam int AW    = 5;
  localparam int NB    = 4;

  typedef struct packed {
    logic             wr;
    logic             err;
    logic [WIDTH-1:0] rdata;
  } rsp_t;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic             req_wr = 1'b0;
  logic [AW-1:0]    req_addr = '0;
  logic [WIDTH-1:0] req_wdata = '0;
  logic [NB-1:0]    req_be = '0;
  logic             rsp_valid;
  logic             rsp_ready = 1'b1;
  logic             rsp_wr;
  logic [WIDTH-1:0] rsp_rdata;
  logic             rsp_err;
  logic             busy;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  rsp_t             exp_q[$];
  int               hs_cyc[$];
  logic [WIDTH-1:0] model_mem [DEPTH];

  mem_be_resp #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_wr    (req_wr),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_be    (req_be),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_wr    (rsp_wr),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Inputs change #1 after rising edges, so the falling edge sees what the next edge will sample.
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (!rst && rsp_valid && rsp_ready) begin
      rsp_t e;
      checks++;
      hs_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rsp_unexpected: got wr=%0b err=%0b rdata=%h, required no response",
                 rsp_wr, rsp_err, rsp_rdata);
      end else begin
        e = exp_q.pop_front();
        if ({rsp_wr, rsp_err, rsp_rdata} !== e) begin
          errors++;
          $display("FAIL rsp_data: got wr=%0b err=%0b rdata=%h, required wr=%0b err=%0b rdata=%h",
                   rsp_wr, rsp_err, rsp_rdata, e.wr, e.err, e.rdata);
        end
      end
    end
  end

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
  endtask

  // Presents one request (at posedge+1) and returns #1 after the edge that accepts it.
  task automatic send(input logic wr, input logic [AW-1:0] addr,
                      input logic [WIDTH-1:0] d, input logic [NB-1:0] be);
    int   n = 0;
    rsp_t e;
    req_valid = 1'b1;
    req_wr    = wr;
    req_addr  = addr;
    req_wdata = d;
    req_be    = be;
    @(negedge clk);
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      checks++;
      errors++;
      $display("FAIL req_accept_timeout: req_ready=%0b after %0d cycles, required 1", req_ready, n);
      req_valid = 1'b0;
      @(posedge clk); #1;
      return;
    end
    e.wr  = wr;
    e.err = (int'(addr) >= DEPTH);
    e.rdata = '0;
    if (!e.err) begin
      if (wr) begin
        for (int k = 0; k < NB; k++)
          if (be[k]) model_mem[addr][8*k +: 8] = d[8*k +: 8];
      end else begin
        e.rdata = model_mem[addr];
      end
    end
    exp_q.push_back(e);
    @(posedge clk); #1;
  endtask

  task automatic idle();
    req_valid = 1'b0;
    req_wdata = '0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: %0d responses outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic wait_sweep(input string tag);
    int n = 0;
    int rr_bad = 0;
    while (busy && n < 100) begin
      if (req_ready) rr_bad++;
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (n != DEPTH) begin
      errors++;
      $display("FAIL %s_busy_len: busy lasted %0d cycles, required %0d", tag, n, DEPTH);
    end
    checks++;
    if (rr_bad != 0) begin
      errors++;
      $display("FAIL %s_ready_in_clear: req_ready high in %0d clear cycles, required 0", tag, rr_bad);
    end
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    exp_q.delete();
    model_clear();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    pulse_reset();
    checks++;
    if ({rsp_valid, rsp_wr, rsp_err, rsp_rdata, busy, req_ready} !== {3'b000, 32'h0, 2'b10}) begin
      errors++;
      $display("FAIL reset_state: got valid=%0b wr=%0b err=%0b rdata=%h busy=%0b ready=%0b, required 0 0 0 0 1 0",
               rsp_valid, rsp_wr, rsp_err, rsp_rdata, busy, req_ready);
    end
    wait_sweep("reset");
    checks++;
    if (busy !== 1'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL after_sweep: got busy=%0b req_ready=%0b, required 0 1", busy, req_ready);
    end
    for (int a = 0; a < DEPTH; a++) send(1'b0, AW'(a), '0, '0);
    idle();
    drain();
  endtask

  task automatic test_byte_lanes();
    send(1'b1, 5'd5, 32'hAABBCCDD, 4'b1111);
    send(1'b1, 5'd5, 32'h11223344, 4'b0101);
    send(1'b0, 5'd5, '0, '0);
    send(1'b1, 5'd7, 32'h12345678, 4'b1111);
    send(1'b1, 5'd7, 32'hFFFFFFFF, 4'b0000);
    send(1'b0, 5'd7, '0, '0);
    send(1'b1, 5'd23, 32'hCAFEF00D, 4'b1010);
    send(1'b0, 5'd23, '0, '0);
    idle();
    drain();
  endtask

  task automatic test_out_of_range();
    send(1'b1, 5'd30, 32'hFFFFFFFF, 4'b1111);
    send(1'b0, 5'd30, '0, '0);
    send(1'b1, 5'd24, 32'hFFFFFFFF, 4'b1111);
    for (int a = 0; a < DEPTH; a++) send(1'b0, AW'(a), '0, '0);
    idle();
    drain();
  endtask

  task automatic test_backpressure();
    int hs0;
    int held_bad = 0;
    logic [WIDTH-1:0] want;
    rsp_ready = 1'b0;
    want = model_mem[5];
    send(1'b0, 5'd5, '0, '0);
    // A competing write is offered while the slot is full; it must never land.
    req_valid = 1'b1;
    req_wr    = 1'b1;
    req_addr  = 5'd5;
    req_wdata = 32'h0;
    req_be    = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b1 || req_ready !== 1'b0 || rsp_rdata !== want || rsp_err !== 1'b0)
        held_bad++;
      @(posedge clk); #1;
    end
    checks++;
    if (held_bad != 0) begin
      errors++;
      $display("FAIL bp_hold: %0d of 5 cycles not held (rdata=%h), required rdata=%h", held_bad, rsp_rdata, want);
    end
    idle();
    hs0 = hs_cyc.size();
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release: got valid=%0b ready=%0b, required 0 1", rsp_valid, req_ready);
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (hs_cyc.size() - hs0 != 1) begin
      errors++;
      $display("FAIL bp_handshakes: got %0d, required 1", hs_cyc.size() - hs0);
    end
    send(1'b0, 5'd5, '0, '0);
    idle();
    drain();
  endtask

  task automatic test_back_to_back();
    int base;
    int gaps = 0;
    rsp_ready = 1'b1;
    base = hs_cyc.size();
    send(1'b1, 5'd9, 32'h0BADBEEF, 4'b1111);
    send(1'b0, 5'd9, '0, '0);
    for (int a = 0; a < DEPTH; a++) send(1'b0, AW'(a), '0, '0);
    idle();
    drain();
    checks++;
    if (hs_cyc.size() - base != DEPTH + 2) begin
      errors++;
      $display("FAIL stream_count: got %0d responses, required %0d", hs_cyc.size() - base, DEPTH + 2);
    end else begin
      for (int i = base + 1; i < hs_cyc.size(); i++)
        if (hs_cyc[i] != hs_cyc[i-1] + 1) gaps++;
      if (gaps != 0) begin
        errors++;
        $display("FAIL stream_gaps: got %0d gaps, required 0", gaps);
      end
    end
  endtask

  task automatic test_reset_mid();
    rsp_ready = 1'b0;
    send(1'b0, 5'd5, '0, '0);
    idle();
    repeat (2) @(posedge clk);
    #1;
    pulse_reset();
    checks++;
    if (rsp_valid !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL midrst_state: got valid=%0b busy=%0b, required 0 1", rsp_valid, busy);
    end
    wait_sweep("midrst");
    rsp_ready = 1'b1;
    send(1'b0, 5'd5, '0, '0);
    send(1'b0, 5'd9, '0, '0);
    idle();
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  initial begin
    model_clear();
    @(posedge clk); #1;
    test_reset();
    test_byte_lanes();
    test_out_of_range();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
